jk_reg_sequencer: RTL

//  Command-driven controller for an N-bit register bank built from JK cells (SR flop plus J/K steering).

---
 rtl/jk_seq_pkg.sv | 28 ++
 rtl/jk_cell.sv | 39 +++
 rtl/jk_reg_sequencer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/jk_seq_pkg.sv
// rtl/jk_seq_pkg.sv - shared opcodes and FSM encoding for the JK register sequencer
//
// Purpose: opcode constants, controller state type and a small opcode
// classification helper shared by the sequencer top and its testbench model.
// Ports: none (package).
package jk_seq_pkg;

  localparam logic [2:0] OP_NOP    = 3'b000;
  localparam logic [2:0] OP_CLEAR  = 3'b001;
  localparam logic [2:0] OP_SET    = 3'b010;
  localparam logic [2:0] OP_LOAD   = 3'b011;
  localparam logic [2:0] OP_CNT_UP = 3'b100;
  localparam logic [2:0] OP_CNT_DN = 3'b101;
  localparam logic [2:0] OP_TOGGLE = 3'b110;
  localparam logic [2:0] OP_RSVD   = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic is_count_op(input logic [2:0] op);
    return (op == OP_CNT_UP) || (op == OP_CNT_DN);
  endfunction

endpackage

// File: rtl/jk_cell.sv
// rtl/jk_cell.sv - one JK storage bit built from an SR flop with J/K steering
//
// Purpose: single bit of the JK bank. S = j & ~q and R = k & q, so set and
// reset can never be asserted together; j = k = 1 toggles, j = k = 0 holds.
// Ports:
//   clk  in   rising-edge clock
//   rst  in   asynchronous active-high reset (q -> 0)
//   j    in   J steering input
//   k    in   K steering input
//   q    out  stored bit
module jk_cell (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  logic r_q;
  logic w_s;
  logic w_r;

  // Steering gates against the current state keep S and R mutually exclusive.
  assign w_s = j & ~r_q;
  assign w_r = k & r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= 1'b0;
    end else if (w_s) begin
      r_q <= 1'b1;
    end else if (w_r) begin
      r_q <= 1'b0;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/jk_reg_sequencer.sv
// rtl/jk_reg_sequencer.sv - command-driven controller for a WIDTH-bit JK register bank
//
// Purpose: accepts one op at a time over cmd_valid/cmd_ready and drives per-bit
// J/K to clear, set, load, toggle or count the JK bank.
// Optional feature macro: JKSEQ_TC_STICKY_EN adds tc_clr input and tc_sticky output.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   cmd_valid  in   command present
//   cmd_ready  out  command accepted this cycle when high (IDLE only)
//   cmd_op     in   3-bit opcode
//   cmd_data   in   load value / toggle mask
//   cmd_len    in   number of count steps
//   abort      in   stop an in-progress count after the current step
//   q          out  JK bank contents
//   busy       out  high in EXEC and COUNT
//   done       out  one-cycle completion pulse
//   tc         out  one-cycle pulse after q wraps
//   err        out  one-cycle pulse on completion of reserved opcode
//   tc_clr     in   (JKSEQ_TC_STICKY_EN) clear sticky wrap flag
//   tc_sticky  out  (JKSEQ_TC_STICKY_EN) sticky wrap flag
module jk_reg_sequencer
  import jk_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             tc,
  output logic             err
`ifdef JKSEQ_TC_STICKY_EN
  ,
  input  logic             tc_clr,
  output logic             tc_sticky
`endif
);

  state_t           r_state;
  state_t           w_next;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_data;
  logic [LEN_W-1:0] r_rem;
  logic             r_tc;

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic [WIDTH-1:0] w_carry;
  logic             w_accept;
  logic             w_up;
  logic             w_last;
  logic             w_wrap;

  assign w_accept = cmd_valid && (r_state == IDLE);
  assign w_up     = (r_op == OP_CNT_UP);
  assign w_last   = abort || (r_rem == LEN_W'(1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; a zero-length count runs as a NOP through EXEC.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (cmd_valid) w_next = (is_count_op(cmd_op) && (cmd_len != '0)) ? COUNT : EXEC;
      EXEC:    w_next = DONE;
      COUNT:   if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    cmd_ready = (r_state == IDLE);
    busy      = (r_state == EXEC) || (r_state == COUNT);
    done      = (r_state == DONE);
    err       = (r_state == DONE) && (r_op == OP_RSVD);
  end

  // Command latch and remaining-step counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op   <= OP_NOP;
      r_data <= '0;
      r_rem  <= '0;
    end else if (w_accept) begin
      r_op   <= (is_count_op(cmd_op) && (cmd_len == '0)) ? OP_NOP : cmd_op;
      r_data <= cmd_data;
      r_rem  <= cmd_len;
    end else if (r_state == COUNT) begin
      r_rem  <= r_rem - LEN_W'(1);
    end
  end

  // Ripple toggle enables: bit i toggles when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    logic v_run;
    v_run   = 1'b1;
    w_carry = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_carry[i] = v_run;
      v_run      = v_run & (w_up ? w_q[i] : ~w_q[i]);
    end
  end

  // Per-bit J/K decode; everything outside EXEC/COUNT holds the bank.
  always_comb begin
    w_j = '0;
    w_k = '0;
    if (r_state == EXEC) begin
      case (r_op)
        OP_CLEAR:  w_k = '1;
        OP_SET:    w_j = '1;
        OP_LOAD:   begin w_j = r_data; w_k = ~r_data; end
        OP_TOGGLE: begin w_j = r_data; w_k = r_data;  end
        default:   begin w_j = '0; w_k = '0; end
      endcase
    end else if (r_state == COUNT) begin
      w_j = w_carry;
      w_k = w_carry;
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .j   (w_j[gi]),
      .k   (w_k[gi]),
      .q   (w_q[gi])
    );
  end

  // The step about to happen wraps when q is at its extreme in the count direction.
  assign w_wrap = (r_state == COUNT) && (w_up ? (&w_q) : (~|w_q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tc <= 1'b0;
    end else begin
      r_tc <= w_wrap;
    end
  end

  assign q  = w_q;
  assign tc = r_tc;

`ifdef JKSEQ_TC_STICKY_EN
  logic r_tc_sticky;

  // Set wins over clear so a wrap coinciding with tc_clr is not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tc_sticky <= 1'b0;
    end else if (r_tc) begin
      r_tc_sticky <= 1'b1;
    end else if (tc_clr) begin
      r_tc_sticky <= 1'b0;
    end
  end

  assign tc_sticky = r_tc_sticky;
`endif

endmodule
